// File: rtl/recorder_axi_memory_pkg.sv
// recorder_axi_memory_pkg: shared FSM state types for the recorder AXI memory
package recorder_axi_memory_pkg;
  typedef enum logic {W_IDLE, W_DATA} write_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} read_state_t;
endpackage

// File: rtl/recorder_sdp_ram.sv
// recorder_sdp_ram: simple dual-port RAM, byte-enabled write, registered read-first read port
module recorder_sdp_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  localparam int STRB_W = DATA_W / 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < STRB_W; i++)
      if (we && wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
  // Non-blocking read alongside the write yields the pre-write word on a collision.
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/recorder_axi_memory.sv
// recorder_axi_memory: AXI AW/W/AR/R responder backed by a word-addressed on-chip RAM
module recorder_axi_memory
  import recorder_axi_memory_pkg::*;
#(
  parameter int AXI_ID_WIDTH_P = 4,
  parameter int AXI_ADDR_WIDTH_P = 32,
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int AXI_STRB_WIDTH_P = AXI_DATA_WIDTH_P / 8,
  parameter int MEMORY_DEPTH_P = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXI_ID_WIDTH_P-1:0]   awid,
  input  logic [AXI_ADDR_WIDTH_P-1:0] awaddr,
  input  logic [7:0]                  awlen,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [AXI_DATA_WIDTH_P-1:0] wdata,
  input  logic [AXI_STRB_WIDTH_P-1:0] wstrb,
  input  logic                        wlast,
  input  logic                        wvalid,
  output logic                        wready,
  input  logic [AXI_ID_WIDTH_P-1:0]   arid,
  input  logic [AXI_ADDR_WIDTH_P-1:0] araddr,
  input  logic [7:0]                  arlen,
  input  logic                        arvalid,
  output logic                        arready,
  output logic [AXI_ID_WIDTH_P-1:0]   rid,
  output logic [AXI_DATA_WIDTH_P-1:0] rdata,
  output logic                        rlast,
  output logic                        rvalid,
  input  logic                        rready,
  output logic                        sr_addr_error,
  output logic                        sr_wlast_error
);
  localparam int AW = $clog2(MEMORY_DEPTH_P);
  localparam logic [AXI_ADDR_WIDTH_P-1:0] DEPTH_A = AXI_ADDR_WIDTH_P'(MEMORY_DEPTH_P);
  write_state_t w_state;
  read_state_t r_state;
  logic [AXI_ADDR_WIDTH_P-1:0] waddr, raddr;
  logic [7:0] wlen, wcnt, rlen, rcnt;
  logic [AXI_ID_WIDTH_P-1:0] unused_awid_q;
  logic [AXI_DATA_WIDTH_P-1:0] ram_q;
  logic rd_oor;
  logic w_ok, r_ok, wr_beat, rd_fetch, w_end_cnt;
  assign w_ok = waddr < DEPTH_A;
  assign r_ok = raddr < DEPTH_A;
  assign wr_beat = wvalid && wready;
  assign rd_fetch = r_state == R_FETCH;
  assign w_end_cnt = wcnt == wlen;
  assign rdata = rd_oor ? '0 : ram_q;
  recorder_sdp_ram #(.DATA_W(AXI_DATA_WIDTH_P), .DEPTH(MEMORY_DEPTH_P)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(wr_beat && w_ok),
    .waddr(waddr[AW-1:0]),
    .wdata(wdata),
    .wstrb(wstrb),
    .re(rd_fetch && r_ok),
    .raddr(raddr[AW-1:0]),
    .rdata(ram_q)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      wready <= 1'b0;
      waddr <= '0;
      wlen <= '0;
      wcnt <= '0;
      unused_awid_q <= '0;
      sr_wlast_error <= 1'b0;
    end else if (w_state == W_IDLE) begin
      if (awvalid) begin
        waddr <= awaddr;
        wlen <= awlen;
        wcnt <= '0;
        unused_awid_q <= awid;
        awready <= 1'b0;
        wready <= 1'b1;
        w_state <= W_DATA;
      end
    end else if (wr_beat) begin
      waddr <= waddr + 1'b1;
      wcnt <= wcnt + 1'b1;
      // The burst ends on whichever comes first: wlast or the awlen beat count.
      if (wlast || w_end_cnt) begin
        awready <= 1'b1;
        wready <= 1'b0;
        w_state <= W_IDLE;
      end
      if (wlast != w_end_cnt) sr_wlast_error <= 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid <= 1'b0;
      rlast <= 1'b0;
      rid <= '0;
      raddr <= '0;
      rlen <= '0;
      rcnt <= '0;
      rd_oor <= 1'b0;
    end else begin
      unique case (r_state)
        R_IDLE:
          if (arvalid) begin
            raddr <= araddr;
            rlen <= arlen;
            rid <= arid;
            rcnt <= '0;
            arready <= 1'b0;
            r_state <= R_FETCH;
          end
        R_FETCH: begin
          rd_oor <= !r_ok;
          rvalid <= 1'b1;
          rlast <= rcnt == rlen;
          r_state <= R_DATA;
        end
        default:
          if (rready) begin
            rvalid <= 1'b0;
            rlast <= 1'b0;
            if (rlast) begin
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              raddr <= raddr + 1'b1;
              rcnt <= rcnt + 1'b1;
              r_state <= R_FETCH;
            end
          end
      endcase
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) sr_addr_error <= 1'b0;
    else if ((wr_beat && !w_ok) || (rd_fetch && !r_ok)) sr_addr_error <= 1'b1;
endmodule

// File: tb/tb_recorder_axi_memory.sv
// tb_recorder_axi_memory: directed self-checking bench for recorder_axi_memory
module tb_recorder_axi_memory;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] awid = '0, arid = '0, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0] awlen = '0, arlen = '0;
  logic [3:0] wstrb = '0;
  logic awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
  logic sr_addr_error, sr_wlast_error;
  int checks = 0;
  int errors = 0;
  logic [31:0] wbuf [8];
  logic [31:0] rbuf [8];
  logic rlbuf [8];
  int first_lat;

  always #5 clk = ~clk;

  recorder_axi_memory dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .sr_addr_error(sr_addr_error), .sr_wlast_error(sr_wlast_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_hi(input string tag, ref logic sig, output int cyc);
    cyc = 0;
    while (sig !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (sig !== 1'b1) begin
      errors++;
      $display("FAIL timeout %s observed=0 expected=1", tag);
    end
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input int nbeats, input logic [3:0] strb);
    int cyc;
    @(negedge clk);
    awvalid = 1'b1; awaddr = addr; awlen = len; awid = 4'h3;
    wait_hi("awready", awready, cyc);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb; wlast = (i == nbeats - 1);
      wait_hi("wready", wready, cyc);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id, input bit stall);
    int cyc;
    @(negedge clk);
    arvalid = 1'b1; araddr = addr; arlen = len; arid = id;
    wait_hi("arready", arready, cyc);
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wait_hi("rvalid", rvalid, cyc);
      if (i == 0) first_lat = cyc;
      rbuf[i] = rdata; rlbuf[i] = rlast;
      if (stall) begin
        @(negedge clk);
        check("rdata_stall", rdata, rbuf[i]);
        check("rvalid_stall", {31'b0, rvalid}, 32'd1);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_awready", {31'b0, awready}, 32'd1);
    check("rst_wready", {31'b0, wready}, 32'd0);
    check("rst_arready", {31'b0, arready}, 32'd1);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_rlast", {31'b0, rlast}, 32'd0);
    check("rst_rid", {28'b0, rid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_flags", {30'b0, sr_addr_error, sr_wlast_error}, 32'd0);
    rst = 1'b0;
    // single write/read
    wbuf[0] = 32'hDEADBEEF;
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'd5; awlen = 8'd0;
    @(negedge clk);
    awvalid = 1'b0;
    check("aw_to_wready", {31'b0, wready}, 32'd1);
    check("aw_busy", {31'b0, awready}, 32'd0);
    wvalid = 1'b1; wdata = wbuf[0]; wstrb = 4'hF; wlast = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    check("w_done_awready", {31'b0, awready}, 32'd1);
    read_burst(32'd5, 8'd0, 4'h9, 1'b0);
    check("t1_rdata", rbuf[0], 32'hDEADBEEF);
    check("t1_rlast", {31'b0, rlbuf[0]}, 32'd1);
    check("t1_rid", {28'b0, rid}, 32'h9);
    check("t1_lat", first_lat, 32'd1);
    // burst with stalled reads
    for (int i = 0; i < 4; i++) wbuf[i] = i + 1;
    write_burst(32'd10, 8'd3, 4, 4'hF);
    read_burst(32'd10, 8'd3, 4'h2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t2_rdata", rbuf[i], i + 1);
      check("t2_rlast", {31'b0, rlbuf[i]}, (i == 3) ? 32'd1 : 32'd0);
    end
    check("t2_wlast_err", {31'b0, sr_wlast_error}, 32'd0);
    // byte strobes
    wbuf[0] = 32'hFFFFFFFF;
    write_burst(32'd20, 8'd0, 1, 4'hF);
    wbuf[0] = 32'h00000000;
    write_burst(32'd20, 8'd0, 1, 4'b0101);
    read_burst(32'd20, 8'd0, 4'h1, 1'b0);
    check("t3_rdata", rbuf[0], 32'hFF00FF00);
    check("t3_addr_err", {31'b0, sr_addr_error}, 32'd0);
    // out of range
    wbuf[0] = 32'hA5A5A5A5; wbuf[1] = 32'h5A5A5A5A;
    write_burst(32'd1023, 8'd1, 2, 4'hF);
    check("t4_addr_err", {31'b0, sr_addr_error}, 32'd1);
    check("t4_awready", {31'b0, awready}, 32'd1);
    read_burst(32'd1023, 8'd1, 4'h4, 1'b0);
    check("t4_beat0", rbuf[0], 32'hA5A5A5A5);
    check("t4_beat1", rbuf[1], 32'd0);
    check("t4_rlast", {31'b0, rlbuf[1]}, 32'd1);
    // early wlast
    wbuf[0] = 32'h11; wbuf[1] = 32'h22;
    write_burst(32'd40, 8'd3, 2, 4'hF);
    check("t5_wlast_err", {31'b0, sr_wlast_error}, 32'd1);
    check("t5_awready", {31'b0, awready}, 32'd1);
    check("t5_wready", {31'b0, wready}, 32'd0);
    read_burst(32'd40, 8'd1, 4'h6, 1'b0);
    check("t5_beat0", rbuf[0], 32'h11);
    check("t5_beat1", rbuf[1], 32'h22);
    // reset mid read burst
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'd10; arlen = 8'd3; arid = 4'h7;
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    check("t6_rvalid_pre", {31'b0, rvalid}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rvalid", {31'b0, rvalid}, 32'd0);
    check("t6_arready", {31'b0, arready}, 32'd1);
    check("t6_flags", {30'b0, sr_addr_error, sr_wlast_error}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    read_burst(32'd5, 8'd0, 4'hC, 1'b0);
    check("t6_rdata", rbuf[0], 32'hDEADBEEF);
    check("t6_rid", {28'b0, rid}, 32'hC);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
